// File: rtl/ls163_chain_pkg.sv
// Shared TTL constants for the 74LS163 counter cascade.
// Stage width, terminal count and cascade depth bound.
package ls163_chain_pkg;
  localparam int unsigned STAGE_W = 4;
  localparam logic [STAGE_W-1:0] TERM_CNT = 4'hF;
  localparam int unsigned MAX_STAGES = 4;
endpackage

// File: rtl/ls163_chain_ls163.sv
// Single 74LS163 4-bit synchronous binary counter stage.
// Clear beats load, load beats count; RCO is combinational.
module ls163
  import ls163_chain_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               nCLR,
  input  logic               nLOAD,
  input  logic               ENP,
  input  logic               ENT,
  input  logic [STAGE_W-1:0] D,
  output logic [STAGE_W-1:0] Q,
  output logic               RCO
);

  always_ff @(posedge clk) begin
    if (rst)
      Q <= '0;
    else if (!nCLR)
      Q <= '0;
    else if (!nLOAD)
      Q <= D;
    else if (ENP && ENT)
      Q <= Q + 1'b1;
  end

  assign RCO = ENT & (Q == TERM_CNT);

endmodule

// File: rtl/ls163_chain.sv
// Ripple-carry cascade of ls163 stages forming a 4*STAGES bit counter.
// Each stage's RCO feeds the next stage's ENT; ENP is shared.
module ls163_chain
  import ls163_chain_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      nCLR,
  input  logic                      nLOAD,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic [STAGE_W*STAGES-1:0] D,
  output logic [STAGE_W*STAGES-1:0] Q,
  output logic                      RCO,
  output logic [STAGES-1:0]         RCO_STAGE
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : gBadStages
    $fatal(1, "ls163_chain: STAGES must be 1..%0d", MAX_STAGES);
  end

  logic [STAGES:0] entChain;

  assign entChain[0] = ENT;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    ls163 uStage (
      .clk   (clk),
      .rst   (rst),
      .nCLR  (nCLR),
      .nLOAD (nLOAD),
      .ENP   (ENP),
      .ENT   (entChain[k]),
      .D     (D[STAGE_W*k +: STAGE_W]),
      .Q     (Q[STAGE_W*k +: STAGE_W]),
      .RCO   (RCO_STAGE[k])
    );
    assign entChain[k+1] = RCO_STAGE[k];
  end

  assign RCO = RCO_STAGE[STAGES-1];

endmodule

// File: tb/tb_ls163_chain.sv
// Self-checking bench for ls163_chain with STAGES = 2.
// Arithmetic reference model plus directed literal checks.
module tb_ls163_chain;
  localparam int STAGES = 2;
  localparam int W = 4 * STAGES;

  logic clk = 1'b0;
  logic rst, nCLR, nLOAD, ENP, ENT;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic RCO;
  logic [STAGES-1:0] RCO_STAGE;

  int errors = 0;
  int checks = 0;
  bit chk = 0;
  int qm = 0;

  ls163_chain #(.STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .nCLR      (nCLR),
    .nLOAD     (nLOAD),
    .ENP       (ENP),
    .ENT       (ENT),
    .D         (D),
    .Q         (Q),
    .RCO       (RCO),
    .RCO_STAGE (RCO_STAGE)
  );

  always #5 clk = ~clk;

  // Reference: whole-word counter with the cascade carries derived arithmetically.
  always @(posedge clk) begin
    if (rst || !nCLR)
      qm = 0;
    else if (!nLOAD)
      qm = int'(D);
    else if (ENP && ENT)
      qm = (qm + 1) % (1 << W);
  end

  function automatic logic [STAGES-1:0] modelRco(input int q, input logic ent);
    logic [STAGES-1:0] r;
    for (int k = 0; k < STAGES; k++) begin
      int m;
      m = 1 << (4 * (k + 1));
      r[k] = ent && ((q % m) == m - 1);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      logic [STAGES-1:0] er;
      er = modelRco(qm, ENT);
      checks++;
      if (Q !== W'(qm) || RCO_STAGE !== er || RCO !== er[STAGES-1]) begin
        errors++;
        $display("FAIL model t=%0t Q=%h RCO_STAGE=%b RCO=%b want Q=%h RCO_STAGE=%b RCO=%b",
                 $time, Q, RCO_STAGE, RCO, W'(qm), er, er[STAGES-1]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit(input string nm, input logic [W-1:0] eq,
                     input logic [STAGES-1:0] ers);
    checks++;
    if (Q !== eq || RCO_STAGE !== ers || RCO !== ers[STAGES-1]) begin
      errors++;
      $display("FAIL %s Q=%h RCO_STAGE=%b RCO=%b want Q=%h RCO_STAGE=%b RCO=%b",
               nm, Q, RCO_STAGE, RCO, eq, ers, ers[STAGES-1]);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    nLOAD = 1'b0;
    D = v;
    step(1);
    nLOAD = 1'b1;
  endtask

  initial begin
    rst = 1'b1; nCLR = 1'b1; nLOAD = 1'b0;
    D = 8'hA5; ENP = 1'b0; ENT = 1'b0;
    step(1);
    chk = 1;
    step(1);
    lit("reset", 8'h00, 2'b00);

    rst = 1'b0; nLOAD = 1'b1; ENP = 1'b1; ENT = 1'b1;
    step(1);
    lit("release", 8'h01, 2'b00);

    load(8'h0E);
    lit("load0E", 8'h0E, 2'b00);
    step(1);
    lit("cnt0F", 8'h0F, 2'b01);
    step(1);
    lit("carry10", 8'h10, 2'b00);

    load(8'hFF);
    lit("tcFF", 8'hFF, 2'b11);
    step(1);
    lit("wrap00", 8'h00, 2'b00);

    ENP = 1'b0;
    load(8'hFF);
    step(1);
    lit("enpHold", 8'hFF, 2'b11);
    ENT = 1'b0;
    #1;
    lit("entGate", 8'hFF, 2'b00);
    step(1);
    lit("entHold", 8'hFF, 2'b00);

    D = 8'h3C;
    load(8'h3C);
    lit("load3C", 8'h3C, 2'b00);
    ENP = 1'b1; ENT = 1'b1;
    #1;
    lit("preLoad", 8'h3C, 2'b00);
    load(8'hFF);
    lit("loadWins", 8'hFF, 2'b11);

    load(8'h57);
    lit("load57", 8'h57, 2'b00);
    nCLR = 1'b0; nLOAD = 1'b0; D = 8'h99;
    step(1);
    nCLR = 1'b1; nLOAD = 1'b1;
    lit("clrWins", 8'h00, 2'b00);

    load(8'h7F);
    step(1);
    lit("mid80", 8'h80, 2'b00);
    rst = 1'b1;
    step(1);
    lit("rstMid", 8'h00, 2'b00);
    rst = 1'b0;
    step(1);
    lit("resume", 8'h01, 2'b00);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (Q[1:0] !== 2'(i % 4) || Q[7:2] !== 6'(i / 4)) begin
        errors++;
        $display("FAIL decode%0d Q=%h want lo=%0d hi=%0d", i, Q, i % 4, i / 4);
      end
      step(1);
    end

    chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ls163_chain.md
# ls163_chain

Cascade of 74LS163 4-bit synchronous binary counters (STAGES stages, ripple-carry linked) for the System86 TTL library. It generates the phase and sequence counts that feed the address inputs of the board's LS139 2-to-4 decoders, for example CPU clock-phase and video-slot strobes. Chip pins (nCLR, nLOAD, ENP, ENT, RCO) keep 74LS163 semantics. A separate FPGA-level reset overrides everything.

## Interface
Parameters:
- STAGES, 2, number of cascaded 4-bit counter stages (1..4); total width W = 4*STAGES.

Ports:
- clk  input  1  single system clock; the chip CLK rising edge maps to this edge.
- rst  input  1  synchronous, active-high reset.
- nCLR  input  1  chip clear, synchronous, active-low.
- nLOAD  input  1  chip parallel load, synchronous, active-low.
- ENP  input  1  count-enable P, shared by all stages.
- ENT  input  1  count-enable T into stage 0; also gates the RCO outputs.
- D  input  W  parallel load data; stage k uses D[4k+3:4k].
- Q  output  W  counter outputs, registered; stage k drives Q[4k+3:4k]. Q[0] is the QA pin.
- RCO  output  1  ripple carry out of the final stage, combinational.
- RCO_STAGE  output  STAGES  per-stage ripple carry, combinational; RCO = RCO_STAGE[STAGES-1].

## Operation
- Per-stage priority at each clk rising edge (highest first):
  - rst = 1: Q_k <= 0.
  - nCLR = 0: Q_k <= 0.
  - nLOAD = 0: Q_k <= D_k. Ignores ENP and ENT.
  - ENP & ENT_k = 1: Q_k <= Q_k + 1 modulo 16.
  - Otherwise: hold.
- rst and nCLR act on every stage in the same cycle. nLOAD loads every stage in the same cycle.
- Cascade enables:
  - ENT_0 = ENT.
  - ENT_k = RCO_STAGE[k-1] for k ≥ 1.
  - ENP goes to every stage unmodified.
- RCO_STAGE[k] = ENT_k & (Q_k == 4'hF). It is purely combinational and never registered.
- Net effect: with ENP = ENT = 1, Q increments as a W-bit binary value each cycle. Wrap from all-ones to 0 takes one cycle.
- ENP = 0 freezes the count but leaves RCO valid (LS163 behaviour). ENT = 0 freezes the count and forces all RCO low.
- Unknown or X on D matters only when nLOAD = 0.

## Timing
- Reset values: Q = 0, RCO_STAGE = 0, RCO = 0 (Q ≠ all-ones).
- Q changes only on clk rising edges; latency from a control change to Q is 1 cycle.
- RCO and RCO_STAGE have 0-cycle latency from Q and ENT (same-cycle combinational).
- Terminal count: RCO = 1 for exactly the cycle in which Q = all-ones and ENT = 1. The next counting edge yields Q = 0 and RCO = 0.
- Simultaneous events:
  - rst with anything: Q = 0.
  - nCLR = 0 with nLOAD = 0: clear wins.
  - nLOAD = 0 with ENP & ENT: load wins. The RCO shown in that cycle reflects the pre-load Q.
- A load of all-ones makes RCO = 1 in the following cycle if ENT = 1.
- rst asserted mid-count takes effect at the next edge. Counting resumes from 0 on the first edge after rst deasserts.
- No asynchronous paths. nCLR is synchronous, as on the real 163, so there is no 161-style async clear.

## Structure
- Sub-module ls163: a single 4-bit stage with ports clk, rst, nCLR, nLOAD, ENP, ENT, D[3:0], Q[3:0], RCO. ls163_chain instantiates it STAGES times in a generate loop and links RCO to the next stage's ENT.
- Shared TTL package holds:
  - the stage width constant (4);
  - the terminal-count constant (4'hF);
  - the maximum STAGES bound.
- Elaboration check: STAGES outside 1..4 is a fatal error.

## Test plan
All scenarios use STAGES = 2.
- Reset: rst = 1 for 2 cycles with nLOAD = 0, D = 8'hA5 -> Q = 8'h00, RCO = 0. Release rst with ENP = ENT = 1 -> Q = 8'h01 after 1 edge.
- Count and cascade: from Q = 8'h0E with ENP = ENT = 1 -> 8'h0F (RCO_STAGE = 2'b01), then 8'h10. From 8'hFF (RCO = 1) -> 8'h00, RCO = 0.
- Enable gating:
  - At Q = 8'hFF, ENP = 0, ENT = 1 -> Q holds at 8'hFF, RCO = 1.
  - ENT = 0 -> Q holds, RCO = 0, RCO_STAGE = 0.
- Load priority: nLOAD = 0, D = 8'h3C, ENP = ENT = 0 -> Q = 8'h3C next edge. Next, nLOAD = 0 with D = 8'hFF and ENP = ENT = 1 -> Q = 8'hFF, RCO = 1 the same cycle after the edge.
- Clear priority: at Q = 8'h57, nCLR = 0 and nLOAD = 0 with D = 8'h99 -> Q = 8'h00. Then rst = 1 with nCLR = 1 mid-count at 8'h80 -> 8'h00.
- Decoder drive: free-run from 0 for 8 cycles -> Q[1:0] sequence 0,1,2,3,0,1,2,3 and Q[7:2] increments every 4 cycles.
